// File: rtl/tone_voice_pkg.sv
// Shared types and constants for the tone_voice triangle/ADSR voice.
// Holds the envelope state encoding, default envelope shaping constants,
// datapath widths and the phase-to-triangle mapping helper.
package tone_voice_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned DIV_W    = 16;
  localparam int unsigned PHASE_W  = 8;
  localparam int unsigned LEVEL_W  = 8;

  localparam int unsigned DEF_SAMPLE_DIV    = 1000;
  localparam int unsigned DEF_ATTACK_STEP   = 4;
  localparam int unsigned DEF_DECAY_STEP    = 1;
  localparam int unsigned DEF_SUSTAIN_LEVEL = 192;
  localparam int unsigned DEF_RELEASE_STEP  = 2;

  typedef enum logic [2:0] {
    ENV_IDLE    = 3'd0,
    ENV_ATTACK  = 3'd1,
    ENV_DECAY   = 3'd2,
    ENV_SUSTAIN = 3'd3,
    ENV_RELEASE = 3'd4
  } env_state_t;

  // Fold the 8-bit phase into a 0..127 ramp and centre it to -64..63.
  function automatic logic signed [7:0] tri_wave(input logic [7:0] ph);
    logic [6:0] t;
    t = ph[7] ? ~ph[6:0] : ph[6:0];
    return $signed({1'b0, t}) - 8'sd64;
  endfunction

endpackage

// File: rtl/tone_voice_if.sv
// Note-sequencer to voice link.
//   phase_divider : clk48m cycles per phase step, taken on trigger
//   trigger       : one-cycle pulse, start a new note
//   dehold        : one-cycle pulse, release the current note
//   sample        : signed audio sample
//   sample_valid  : one-cycle strobe, sample updated this cycle
interface tone_voice_if;
  import tone_voice_pkg::*;

  logic [DIV_W-1:0]           phase_divider;
  logic                       trigger;
  logic                       dehold;
  logic signed [SAMPLE_W-1:0] sample;
  logic                       sample_valid;

  modport master (
    output phase_divider, trigger, dehold,
    input  sample, sample_valid
  );

  modport slave (
    input  phase_divider, trigger, dehold,
    output sample, sample_valid
  );
endinterface

// File: rtl/tone_env.sv
// ADSR envelope: state machine plus 8-bit level register.
//   clk48m, rst : clock, synchronous active-high reset
//   trigger     : enter ATTACK from any state (level kept)
//   dehold      : enter RELEASE from ATTACK/DECAY/SUSTAIN
//   tick        : sample-rate strobe; level only moves on ticks
//   level       : current envelope level, 0..255
module tone_env
  import tone_voice_pkg::*;
#(
  parameter int unsigned ATTACK_STEP   = DEF_ATTACK_STEP,
  parameter int unsigned DECAY_STEP    = DEF_DECAY_STEP,
  parameter int unsigned SUSTAIN_LEVEL = DEF_SUSTAIN_LEVEL,
  parameter int unsigned RELEASE_STEP  = DEF_RELEASE_STEP
) (
  input  logic               clk48m,
  input  logic               rst,
  input  logic               trigger,
  input  logic               dehold,
  input  logic               tick,
  output logic [LEVEL_W-1:0] level
);

  env_state_t         state, state_d;
  logic [LEVEL_W-1:0] level_d;

  // 9-bit intermediates: bit 8 flags overflow (attack) or borrow (decay/release).
  logic [LEVEL_W:0] att_sum, dec_diff, rel_diff;
  logic             att_full, dec_floor, rel_zero;
  logic             dehold_act, env_event;

  assign att_sum  = {1'b0, level} + 9'(ATTACK_STEP);
  assign dec_diff = {1'b0, level} - 9'(DECAY_STEP);
  assign rel_diff = {1'b0, level} - 9'(RELEASE_STEP);

  assign att_full  = (att_sum >= 9'd255);
  assign dec_floor = dec_diff[LEVEL_W] || (dec_diff <= 9'(SUSTAIN_LEVEL));
  assign rel_zero  = rel_diff[LEVEL_W] || (rel_diff == 9'd0);

  assign dehold_act = dehold && (state inside {ENV_ATTACK, ENV_DECAY, ENV_SUSTAIN});
  // Any accepted note event freezes the level for that cycle, even on a tick.
  assign env_event  = trigger || dehold_act;

  // State and level registers.
  always_ff @(posedge clk48m) begin
    if (rst) begin
      state <= ENV_IDLE;
      level <= '0;
    end else begin
      state <= state_d;
      level <= level_d;
    end
  end

  // Next-state: trigger beats dehold, which beats tick-driven progress.
  always_comb begin
    state_d = state;
    if (trigger) begin
      state_d = ENV_ATTACK;
    end else if (dehold_act) begin
      state_d = ENV_RELEASE;
    end else if (tick) begin
      case (state)
        ENV_ATTACK:  if (att_full)  state_d = ENV_DECAY;
        ENV_DECAY:   if (dec_floor) state_d = ENV_SUSTAIN;
        ENV_RELEASE: if (rel_zero)  state_d = ENV_IDLE;
        default:     state_d = state;
      endcase
    end
  end

  // Level update with saturation/clamping per state.
  always_comb begin
    level_d = level;
    if (tick && !env_event) begin
      case (state)
        ENV_ATTACK:  level_d = att_full  ? 8'hFF : att_sum[LEVEL_W-1:0];
        ENV_DECAY:   level_d = dec_floor ? 8'(SUSTAIN_LEVEL) : dec_diff[LEVEL_W-1:0];
        ENV_RELEASE: level_d = rel_zero  ? 8'd0 : rel_diff[LEVEL_W-1:0];
        ENV_IDLE:    level_d = 8'd0;
        default:     level_d = level;
      endcase
    end
  end

endmodule

// File: rtl/tone_voice.sv
// Single-voice triangle generator with ADSR envelope.
//   clk48m : sole clock
//   rst    : synchronous active-high reset
//   bus    : slave side of tone_voice_if (phase_divider/trigger/dehold in,
//            sample/sample_valid out)
// A sample is produced every SAMPLE_DIV cycles as wave * level * 2.
module tone_voice
  import tone_voice_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV    = DEF_SAMPLE_DIV,
  parameter int unsigned ATTACK_STEP   = DEF_ATTACK_STEP,
  parameter int unsigned DECAY_STEP    = DEF_DECAY_STEP,
  parameter int unsigned SUSTAIN_LEVEL = DEF_SUSTAIN_LEVEL,
  parameter int unsigned RELEASE_STEP  = DEF_RELEASE_STEP
) (
  input  logic        clk48m,
  input  logic        rst,
  tone_voice_if.slave bus
);

  localparam int unsigned SCNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [SCNT_W-1:0]  scnt;
  logic               tick;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   pcnt;
  logic [PHASE_W-1:0] phase;
  logic [LEVEL_W-1:0] level;

  logic signed [7:0]          wave;
  logic signed [SAMPLE_W-1:0] wave_ext, level_ext, product;

  // Free-running sample-rate counter; note events never disturb it.
  assign tick = (scnt == SCNT_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk48m) begin
    if (rst || tick) scnt <= '0;
    else             scnt <= scnt + SCNT_W'(1);
  end

  // Phase accumulator; a zero divider freezes the waveform.
  always_ff @(posedge clk48m) begin
    if (rst) begin
      div_q <= '0;
      pcnt  <= '0;
      phase <= '0;
    end else if (bus.trigger) begin
      div_q <= bus.phase_divider;
      pcnt  <= '0;
      phase <= '0;
    end else if (div_q != '0) begin
      if (pcnt == div_q - DIV_W'(1)) begin
        pcnt  <= '0;
        phase <= phase + PHASE_W'(1);
      end else begin
        pcnt <= pcnt + DIV_W'(1);
      end
    end
  end

  tone_env #(
    .ATTACK_STEP   (ATTACK_STEP),
    .DECAY_STEP    (DECAY_STEP),
    .SUSTAIN_LEVEL (SUSTAIN_LEVEL),
    .RELEASE_STEP  (RELEASE_STEP)
  ) u_env (
    .clk48m  (clk48m),
    .rst     (rst),
    .trigger (bus.trigger),
    .dehold  (bus.dehold),
    .tick    (tick),
    .level   (level)
  );

  // |wave*level| <= 16320, so the 16-bit product and its doubling never overflow.
  assign wave      = tri_wave(phase);
  assign wave_ext  = SAMPLE_W'(wave);
  assign level_ext = $signed(SAMPLE_W'(level));
  assign product   = wave_ext * level_ext;

  // Output registers: sample uses the pre-update level of the tick cycle.
  always_ff @(posedge clk48m) begin
    if (rst) begin
      bus.sample       <= '0;
      bus.sample_valid <= 1'b0;
    end else begin
      bus.sample_valid <= tick;
      if (tick) bus.sample <= product <<< 1;
    end
  end

endmodule

// File: doc/tone_voice.md
# tone_voice

Single-voice sound generator directly downstream of the note sequencer: consumes its `phase_divider`, `trigger` and `dehold` strobes and produces a 16-bit signed triangle-wave sample stream, shaped by an ADSR envelope, at a fixed sample rate derived from `clk48m`. Output feeds the audio output/DAC serializer stage.

## Interface
- `SAMPLE_DIV`, 1000: `clk48m` cycles per output sample (48 kHz).
- `ATTACK_STEP`, 4: envelope increment per sample tick in ATTACK.
- `DECAY_STEP`, 1: envelope decrement per tick in DECAY.
- `SUSTAIN_LEVEL`, 192: DECAY target level, 8-bit.
- `RELEASE_STEP`, 2: envelope decrement per tick in RELEASE.
- `clk48m` in 1: sole clock.
- `rst` in 1: reset, synchronous, active-high.
- `phase_divider` in 16: `clk48m` cycles per phase step; sampled only when `trigger`=1.
- `trigger` in 1: one-cycle pulse, start new note.
- `dehold` in 1: one-cycle pulse, release current note.
- `sample` out 16: signed audio sample.
- `sample_valid` out 1: one-cycle strobe, `sample` updated this cycle.

## Operation
- Divider latch `div_q` (16 b): loaded from `phase_divider` when `trigger`=1.
- Phase: counter `pcnt` (16 b) and index `phase` (8 b). On `trigger`: `pcnt`←0, `phase`←0. Otherwise, if `div_q`≠0: `pcnt`==`div_q`-1 → `pcnt`←0, `phase`←`phase`+1 (255 wraps to 0); else `pcnt`+1. If `div_q`==0, both frozen.
- Waveform period = 256·`div_q` cycles.
- Triangle: `tri7` = `phase[7]` ? ~`phase[6:0]` : `phase[6:0]` (0..127); `wave` = `tri7`−64 (signed, −64..63).
- Envelope: `level` 8 b unsigned; states IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
  - `trigger` (any state) → ATTACK; `level` retained (no restart from 0).
  - `dehold` in ATTACK/DECAY/SUSTAIN → RELEASE; ignored in IDLE/RELEASE.
  - `trigger` and `dehold` in the same cycle: `trigger` wins.
  - Per sample tick only: ATTACK `level`+=ATTACK_STEP, saturating at 255; on reaching 255 → DECAY. DECAY `level`−=DECAY_STEP, clamped at SUSTAIN_LEVEL; on reaching it → SUSTAIN. SUSTAIN holds. RELEASE `level`−=RELEASE_STEP, clamped at 0; on reaching 0 → IDLE. IDLE holds at 0.
  - Saturation computed in 9-bit intermediates; never wraps.
  - Event (`trigger`/`dehold`) on a tick cycle: state transition applies, `level` unchanged that tick.
- Sample: `sample` = `wave` × `level` × 2, signed 16 b (range −32640..32130, no overflow).

## Timing
- Sample counter `scnt` runs 0..SAMPLE_DIV−1 continuously, unaffected by note events; tick = (`scnt`==SAMPLE_DIV−1).
- On the tick edge, `sample` is loaded from the current-cycle `wave` and pre-update `level`, and `sample_valid`←1. The next edge clears `sample_valid`. One strobe every SAMPLE_DIV cycles.
- `trigger` affects `phase`/`pcnt`/state on the very next edge; `phase_divider` ignored outside `trigger` cycles.
- Reset values: `sample`=0, `sample_valid`=0, `scnt`=0, `pcnt`=0, `phase`=0, `div_q`=0, `level`=0, state IDLE.
- `rst` mid-note returns all state to reset values at the next edge. `trigger`/`dehold` in a `rst` cycle are ignored.

## Structure
- Package `tone_voice_pkg`: envelope state enum, default step/level constants, sample width.
- Sub-module `tone_env`: envelope FSM plus `level` register. Inputs: `trigger`, `dehold`, tick. Output: `level`.
- Top: phase counter, sample counter, triangle map and multiply/output registers.

## Test plan
- Reset: release `rst`. First `sample_valid` high after the 1000th edge with `rst` low, `sample`=0. Strobes then recur every 1000 cycles.
- Phase: `trigger` with `phase_divider`=3. `phase` increments every 3 cycles and wraps 255→0 after 768 cycles. `phase_divider` changes without `trigger` have no effect.
- Attack/decay: `trigger` from IDLE. `level` reads 4, 8, … per tick and reaches 255 on tick 64 (DECAY). It then falls 1/tick and reaches 192 after 63 more ticks (SUSTAIN).
- Release: `dehold` in SUSTAIN at 192. `level` falls 2/tick and reaches 0 on tick 96 (IDLE). Every later `sample`=0.
- Retrigger: `trigger` with `phase_divider`=50 during RELEASE at `level`=100. ATTACK resumes from 100 (next tick 104), `phase`=0 and `div_q`=50.
- Corners: `trigger` and `dehold` in the same cycle → ATTACK. `dehold` on a tick cycle in SUSTAIN → RELEASE with `level` unchanged that tick. `rst` mid-ATTACK → all outputs 0 next edge.
